// File: rtl/alarm_bank_if.sv
// alarm_bank_if: time base, configuration write port, user buttons and buzzer outputs of the alarm bank.
// Latency: none (signal bundle only).
// Backpressure: none; all strobes are single-cycle pulses with no handshake.
interface alarm_bank_if #(
  parameter int NUM_ALARMS = 4,
  parameter int IDXW       = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
);
  logic                  tick_1hz;
  logic [23:0]           time_in;
  logic [2:0]            weekday_in;
  logic                  wr_en;
  logic [IDXW-1:0]       wr_idx;
  logic [15:0]           wr_time;
  logic [6:0]            wr_mask;
  logic                  wr_enable;
  logic                  snooze;
  logic                  dismiss;
  logic                  ring;
  logic [IDXW-1:0]       ring_idx;
  logic [NUM_ALARMS-1:0] pending;

  modport master (
    output tick_1hz, time_in, weekday_in,
    output wr_en, wr_idx, wr_time, wr_mask, wr_enable,
    output snooze, dismiss,
    input  ring, ring_idx, pending
  );

  modport slave (
    input  tick_1hz, time_in, weekday_in,
    input  wr_en, wr_idx, wr_time, wr_mask, wr_enable,
    input  snooze, dismiss,
    output ring, ring_idx, pending
  );
endinterface

// File: rtl/alarm_bank.sv
// alarm_bank: weekday-masked BCD alarm channels sharing one buzzer; snooze built only with `ALARM_SNOOZE_EN.
// Latency: ring asserts one clk after the triggering tick_1hz; configuration writes take effect the next clk.
// Backpressure: none; triggers that cannot ring at once are held in per-channel pending flags.
module alarm_bank #(
  parameter int NUM_ALARMS = 4,
  parameter int RING_SECS  = 60,
  parameter int SNOOZE_MIN = 5,
  parameter int MAX_SNOOZE = 3
) (
  input  logic        clk,
  input  logic        rst,
  alarm_bank_if.slave bus
);

  localparam int IDXW = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1;
  localparam logic [7:0] RING_LAST = 8'(RING_SECS - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RINGING = 2'd1
`ifdef ALARM_SNOOZE_EN
    , ST_SNOOZED = 2'd2
`endif
  } state_t;

  state_t                state;
  logic                  ring_q;
  logic [IDXW-1:0]       ring_idx_q;
  logic [NUM_ALARMS-1:0] pend_q;
  logic [7:0]            ring_cnt;

  logic [NUM_ALARMS-1:0] ch_en;
  logic [15:0]           ch_time [NUM_ALARMS];
  logic [6:0]            ch_mask [NUM_ALARMS];

  logic                  idx_ok;
  logic                  time_ok;
  logic                  wr_ok;
  logic                  wr_abort;
  logic [7:0]            wd_sel;
  logic [NUM_ALARMS-1:0] trig;
  logic [NUM_ALARMS-1:0] cand;
  logic [NUM_ALARMS-1:0] win_oh;
  logic [NUM_ALARMS-1:0] act_oh;
  logic [IDXW-1:0]       win_idx;

  // Qualify a configuration write: channel in range and a legal BCD hh:mm.
  always_comb begin
    idx_ok  = (int'(bus.wr_idx) < NUM_ALARMS);
    time_ok = (bus.wr_time[15:12] <= 4'd2) && (bus.wr_time[11:8] <= 4'd9) &&
              (bus.wr_time[7:4]   <= 4'd5) && (bus.wr_time[3:0]  <= 4'd9) &&
              !((bus.wr_time[15:12] == 4'd2) && (bus.wr_time[11:8] > 4'd3));
    wr_ok    = bus.wr_en && idx_ok && time_ok;
    wr_abort = wr_ok && (state != ST_IDLE) && (bus.wr_idx == ring_idx_q);
  end

  // Per-channel configuration registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ch_en <= '0;
      for (int i = 0; i < NUM_ALARMS; i++) begin
        ch_time[i] <= 16'h0000;
        ch_mask[i] <= 7'h00;
      end
    end else if (wr_ok) begin
      for (int i = 0; i < NUM_ALARMS; i++) begin
        if (bus.wr_idx == IDXW'(i)) begin
          ch_en[i]   <= bus.wr_enable;
          ch_time[i] <= bus.wr_time;
          ch_mask[i] <= bus.wr_mask;
        end
      end
    end
  end

  // Weekday 7 maps onto the always-zero mask bit, so it can never match.
  assign wd_sel = 8'b1 << bus.weekday_in;

  // Trigger detection, lowest-index arbitration and one-hot decodes.
  always_comb begin
    trig    = '0;
    win_oh  = '0;
    act_oh  = '0;
    win_idx = '0;
    for (int i = 0; i < NUM_ALARMS; i++) begin
      trig[i] = bus.tick_1hz && ch_en[i] && (bus.weekday_in != 3'd7) &&
                (|({1'b0, ch_mask[i]} & wd_sel)) &&
                (bus.time_in[23:8] == ch_time[i]) && (bus.time_in[7:0] == 8'h00);
    end
    cand = pend_q | trig;
    for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
      if (cand[i]) win_idx = IDXW'(i);
    end
    for (int i = 0; i < NUM_ALARMS; i++) begin
      win_oh[i] = (win_idx == IDXW'(i));
      act_oh[i] = (ring_idx_q == IDXW'(i));
    end
  end

`ifdef ALARM_SNOOZE_EN
  localparam logic [3:0] SN_ADD  = 4'(SNOOZE_MIN);
  localparam logic [3:0] SN_WRAP = 4'(10 - SNOOZE_MIN);
  localparam logic [2:0] SNZ_MAX = 3'(MAX_SNOOZE);

  logic [2:0]  snz_cnt;
  logic [15:0] snz_target;
  logic [15:0] snz_next;
  logic        snz_hit;
  logic [3:0]  sa_ht, sa_hu, sa_mt, sa_mu;
  logic        sa_cm, sa_ch;

  // BCD add of SNOOZE_MIN minutes to the current hh:mm, wrapping 23:59 to 00:00.
  always_comb begin
    sa_ht = bus.time_in[23:20];
    sa_hu = bus.time_in[19:16];
    sa_mt = bus.time_in[15:12];
    sa_mu = bus.time_in[11:8];
    sa_cm = 1'b0;
    sa_ch = 1'b0;
    if (sa_mu >= SN_WRAP) begin
      sa_mu = sa_mu - SN_WRAP;
      sa_cm = 1'b1;
    end else begin
      sa_mu = sa_mu + SN_ADD;
    end
    if (sa_cm) begin
      if (sa_mt == 4'd5) begin
        sa_mt = 4'd0;
        sa_ch = 1'b1;
      end else begin
        sa_mt = sa_mt + 4'd1;
      end
    end
    if (sa_ch) begin
      if ((sa_ht == 4'd2) && (sa_hu == 4'd3)) begin
        sa_ht = 4'd0;
        sa_hu = 4'd0;
      end else if (sa_hu == 4'd9) begin
        sa_ht = sa_ht + 4'd1;
        sa_hu = 4'd0;
      end else begin
        sa_hu = sa_hu + 4'd1;
      end
    end
    snz_next = {sa_ht, sa_hu, sa_mt, sa_mu};
    snz_hit  = bus.tick_1hz && (bus.time_in == {snz_target, 8'h00});
  end
`else
  logic unused_snooze;
  localparam int unused_snooze_params = SNOOZE_MIN + MAX_SNOOZE;
  assign unused_snooze = bus.snooze;
`endif

  // Ring sequencer; a write to the active channel overrides every other event.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      ring_q     <= 1'b0;
      ring_idx_q <= '0;
      pend_q     <= '0;
      ring_cnt   <= '0;
`ifdef ALARM_SNOOZE_EN
      snz_cnt    <= '0;
      snz_target <= 16'h0000;
`endif
    end else if (wr_abort) begin
      state  <= ST_IDLE;
      ring_q <= 1'b0;
      pend_q <= cand & ~act_oh;
    end else begin
      pend_q <= cand;
      case (state)
        ST_IDLE: begin
`ifdef ALARM_SNOOZE_EN
          snz_cnt <= '0;
`endif
          if (|cand) begin
            state      <= ST_RINGING;
            ring_q     <= 1'b1;
            ring_idx_q <= win_idx;
            ring_cnt   <= '0;
            pend_q     <= cand & ~win_oh;
          end
        end
        ST_RINGING: begin
          if (bus.dismiss) begin
            state  <= ST_IDLE;
            ring_q <= 1'b0;
`ifdef ALARM_SNOOZE_EN
          end else if (bus.snooze && (snz_cnt < SNZ_MAX)) begin
            state      <= ST_SNOOZED;
            ring_q     <= 1'b0;
            snz_target <= snz_next;
            snz_cnt    <= snz_cnt + 3'd1;
`endif
          end else if (bus.tick_1hz) begin
            if (ring_cnt == RING_LAST) begin
              state  <= ST_IDLE;
              ring_q <= 1'b0;
            end else begin
              ring_cnt <= ring_cnt + 8'd1;
            end
          end
        end
`ifdef ALARM_SNOOZE_EN
        ST_SNOOZED: begin
          if (bus.dismiss) begin
            state <= ST_IDLE;
          end else if (snz_hit) begin
            state    <= ST_RINGING;
            ring_q   <= 1'b1;
            ring_cnt <= '0;
          end
        end
`endif
        default: begin
          state  <= ST_IDLE;
          ring_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ring     = ring_q;
  assign bus.ring_idx = ring_idx_q;
  assign bus.pending  = pend_q;

endmodule

// File: tb/tb_alarm_bank.sv
// tb_alarm_bank: directed plus random stimulus against a seconds-of-day reference model, scoreboard-checked.
// Latency: expected outputs are queued at the driving negedge and compared 1 ns after the following posedge.
// Backpressure: none; the monitor consumes one expectation per clock whenever the queue holds one.
`timescale 1ns/1ps
module tb_alarm_bank;
  localparam int N          = 4;
  localparam int IDXW       = 2;
  localparam int RING_SECS  = 60;
  localparam int SNOOZE_MIN = 5;
  localparam int MAX_SNOOZE = 3;
`ifdef ALARM_SNOOZE_EN
  localparam bit SNZ_EN = 1'b1;
`else
  localparam bit SNZ_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  alarm_bank_if #(.NUM_ALARMS(N)) bus ();

  alarm_bank #(
    .NUM_ALARMS(N), .RING_SECS(RING_SECS), .SNOOZE_MIN(SNOOZE_MIN), .MAX_SNOOZE(MAX_SNOOZE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic            ring;
    logic [IDXW-1:0] idx;
    logic [N-1:0]    pend;
    bit              chk_idx;
  } exp_t;
  exp_t exp_q[$];

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: times as integer seconds/minutes of day, mode 0 idle, 1 ringing, 2 snoozed.
  bit       m_en   [N];
  int       m_amin [N];
  bit [6:0] m_mask [N];
  int       m_mode, m_act, m_secs, m_scnt, m_tgt;
  bit [N-1:0] m_pend;

  // Drive values for the next clock.
  bit          d_tick, d_wr, d_wen, d_snz, d_dis;
  int          d_tsec, d_wd, d_widx;
  logic [15:0] d_wtime;
  logic [6:0]  d_wmask;
  int          r_sel;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [23:0] to_bcd(int t);
    int h, m, s;
    h = t / 3600; m = (t / 60) % 60; s = t % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  function automatic logic [15:0] hm_bcd(int mins);
    int h, m;
    h = mins / 60; m = mins % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10)};
  endfunction

  function automatic bit decode_hm(input logic [15:0] v, output int mins);
    int ht, hu, mt, mu;
    ht = int'(v[15:12]); hu = int'(v[11:8]); mt = int'(v[7:4]); mu = int'(v[3:0]);
    mins = (ht * 10 + hu) * 60 + mt * 10 + mu;
    return (ht <= 9) && (hu <= 9) && (mt <= 9) && (mu <= 9) &&
           (ht * 10 + hu <= 23) && (mt * 10 + mu <= 59);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_en[i] = 1'b0; m_amin[i] = 0; m_mask[i] = '0;
    end
    m_mode = 0; m_act = 0; m_secs = 0; m_scnt = 0; m_tgt = 0; m_pend = '0;
  endtask

  task automatic model_step();
    bit [N-1:0] trig;
    int  mins;
    bit  ok, wv;
    int  win;
    exp_t e;
    trig = '0;
    for (int i = 0; i < N; i++)
      if (d_tick && m_en[i] && d_wd != 7 && m_mask[i][d_wd] &&
          (d_tsec % 60 == 0) && (d_tsec / 60 == m_amin[i]))
        trig[i] = 1'b1;
    ok = decode_hm(d_wtime, mins);
    wv = d_wr && (d_widx < N) && ok;
    m_pend |= trig;
    if (wv && m_mode != 0 && d_widx == m_act) begin
      m_mode = 0; m_pend[m_act] = 1'b0; m_scnt = 0;
    end else begin
      case (m_mode)
        0: begin
          win = -1;
          for (int i = N - 1; i >= 0; i--) if (m_pend[i]) win = i;
          if (win >= 0) begin
            m_mode = 1; m_act = win; m_secs = 0; m_pend[win] = 1'b0;
          end
        end
        1: begin
          if (d_dis) begin
            m_mode = 0; m_scnt = 0;
          end else if (SNZ_EN && d_snz && m_scnt < MAX_SNOOZE) begin
            m_mode = 2; m_tgt = (d_tsec / 60 + SNOOZE_MIN) % 1440; m_scnt++;
          end else if (d_tick) begin
            m_secs++;
            if (m_secs == RING_SECS) begin m_mode = 0; m_scnt = 0; end
          end
        end
        default: begin
          if (d_dis) begin
            m_mode = 0; m_scnt = 0;
          end else if (d_tick && d_tsec == m_tgt * 60) begin
            m_mode = 1; m_secs = 0;
          end
        end
      endcase
    end
    if (wv) begin
      m_en[d_widx] = d_wen; m_amin[d_widx] = mins; m_mask[d_widx] = d_wmask;
    end
    e.ring = (m_mode == 1); e.idx = IDXW'(m_act); e.pend = m_pend; e.chk_idx = (m_mode != 0);
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(negedge clk);
    rst            = 1'b1;
    bus.tick_1hz   = d_tick;
    bus.time_in    = to_bcd(d_tsec);
    bus.weekday_in = 3'(d_wd);
    bus.wr_en      = d_wr;
    bus.wr_idx     = IDXW'(d_widx);
    bus.wr_time    = d_wtime;
    bus.wr_mask    = d_wmask;
    bus.wr_enable  = d_wen;
    bus.snooze     = d_snz;
    bus.dismiss    = d_dis;
    model_step();
    d_tick = 1'b0; d_wr = 1'b0; d_snz = 1'b0; d_dis = 1'b0;
  endtask

  task automatic tick_t(int tsec, int wd);
    d_tick = 1'b1; d_tsec = tsec; d_wd = wd; step();
  endtask

  task automatic wr(int idx, logic [15:0] t, logic [6:0] mask, bit en);
    d_wr = 1'b1; d_widx = idx; d_wtime = t; d_wmask = mask; d_wen = en; step();
  endtask

  task automatic press(bit snz, bit dis);
    d_snz = snz; d_dis = dis; step();
  endtask

  // Scoreboard monitor.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("ring", 32'(bus.ring), 32'(e.ring));
        check("pending", 32'(bus.pending), 32'(e.pend));
        if (e.chk_idx) check("ring_idx", 32'(bus.ring_idx), 32'(e.idx));
      end
    end
  end

  initial begin : stim
    bus.tick_1hz = 1'b0; bus.time_in = '0; bus.weekday_in = '0; bus.wr_en = 1'b0;
    bus.wr_idx = '0; bus.wr_time = '0; bus.wr_mask = '0; bus.wr_enable = 1'b0;
    bus.snooze = 1'b0; bus.dismiss = 1'b0;
    d_tick = 0; d_wr = 0; d_wen = 0; d_snz = 0; d_dis = 0;
    d_tsec = 0; d_wd = 0; d_widx = 0; d_wtime = '0; d_wmask = '0;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    check("reset_ring", 32'(bus.ring), 32'd0);
    check("reset_ring_idx", 32'(bus.ring_idx), 32'd0);
    check("reset_pending", 32'(bus.pending), 32'd0);

    // Basic ring and timeout after RING_SECS ticks.
    wr(0, 16'h0730, 7'h7F, 1'b1);
    tick_t(7 * 3600 + 29 * 60 + 59, 1);
    tick_t(7 * 3600 + 30 * 60, 1);
    for (int s = 1; s <= RING_SECS; s++) tick_t(7 * 3600 + 30 * 60 + s, 1);
    step();

    // Priority and pending, then dismiss hands over to the pending channel.
    wr(1, 16'h0600, 7'h7F, 1'b1);
    wr(2, 16'h0600, 7'h7F, 1'b1);
    wr(3, 16'h1200, 7'h00, 1'b0);
    tick_t(6 * 3600, 3);
    step();
    press(1'b0, 1'b1);
    step();
    press(1'b0, 1'b1);
    step();

    // Snooze across midnight, snooze limit, snooze+dismiss.
    wr(0, 16'h2357, 7'h7F, 1'b1);
    tick_t(23 * 3600 + 57 * 60, 2);
    tick_t(23 * 3600 + 57 * 60 + 10, 2);
    press(1'b1, 1'b0);
    tick_t(60, 3);
    tick_t(2 * 60, 3);
    press(1'b1, 1'b0);
    tick_t(7 * 60, 3);
    press(1'b1, 1'b0);
    tick_t(12 * 60, 3);
    press(1'b1, 1'b0);
    step();
    press(1'b1, 1'b1);
    step();

    // Illegal writes are dropped; weekday 7 never triggers.
    wr(0, 16'h2460, 7'h7F, 1'b1);
    wr(1, 16'h0A00, 7'h7F, 1'b0);
    tick_t(23 * 3600 + 57 * 60, 7);
    step();
    tick_t(23 * 3600 + 57 * 60, 4);
    press(1'b0, 1'b1);

    // Rewriting the ringing channel aborts it; the pending channel follows.
    wr(3, 16'h0600, 7'h7F, 1'b1);
    tick_t(6 * 3600, 5);
    wr(1, 16'h0800, 7'h7F, 1'b1);
    step();
    press(1'b0, 1'b1);
    step();

    // Asynchronous reset while ringing with a pending channel.
    tick_t(6 * 3600, 5);
    step();
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("rst_ring", 32'(bus.ring), 32'd0);
    check("rst_pending", 32'(bus.pending), 32'd0);
    check("rst_ring_idx", 32'(bus.ring_idx), 32'd0);
    model_reset();
    repeat (2) @(negedge clk);
    step();
    tick_t(6 * 3600, 5);
    step();

    // Random phase.
    for (int i = 0; i < N; i++) wr(i, hm_bcd($urandom_range(0, 1439)), 7'h7F, 1'b1);
    for (int it = 0; it < 2500; it++) begin
      if ($urandom_range(0, 99) < 8) begin
        d_wr = 1'b1;
        d_widx = $urandom_range(0, N - 1);
        if ($urandom_range(0, 4) == 0) d_wtime = 16'($urandom);
        else d_wtime = hm_bcd($urandom_range(0, 1439));
        d_wmask = 7'($urandom);
        d_wen = ($urandom_range(0, 3) != 0);
      end
      if ($urandom_range(0, 2) == 0) begin
        d_tick = 1'b1;
        r_sel = $urandom_range(0, 3);
        case (r_sel)
          0: d_tsec = m_amin[$urandom_range(0, N - 1)] * 60;
          1: d_tsec = m_tgt * 60;
          2: d_tsec = (d_tsec + 1) % 86400;
          default: d_tsec = $urandom_range(0, 86399);
        endcase
        d_wd = $urandom_range(0, 7);
      end
      if ($urandom_range(0, 9) == 0) d_snz = 1'b1;
      if ($urandom_range(0, 29) == 0) d_dis = 1'b1;
      step();
    end
    step();

    @(posedge clk);
    #2;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/alarm_bank.md
ALARM_BANK -- requirements
Module: alarm_bank

Interface
REQ-001 Parameter NUM_ALARMS, default 4, number of independent alarm channels (1..8).
REQ-002 Parameter RING_SECS, default 60, ring duration in tick_1hz periods (1..255).
REQ-003 Parameter SNOOZE_MIN, default 5, snooze offset in minutes (1..9).
REQ-004 Parameter MAX_SNOOZE, default 3, maximum snoozes per ring event (1..7).
REQ-005 clk  in  1  master clock; single clock domain.
REQ-006 rst  in  1  reset, asynchronous, active-low.
REQ-007 tick_1hz  in  1  one-clk-wide pulse, once per second, aligned with time_in update.
REQ-008 time_in  in  24  current time, BCD hh_mm_ss.
REQ-009 weekday_in  in  3  current weekday 0..6; 7 is invalid.
REQ-010 wr_en  in  1  one-cycle write strobe for alarm configuration.
REQ-011 wr_idx  in  IDXW  channel index; IDXW = max(1, clog2(NUM_ALARMS)).
REQ-012 wr_time  in  16  alarm time, BCD hh_mm.
REQ-013 wr_mask  in  7  weekday enable mask, bit n = weekday n.
REQ-014 wr_enable  in  1  channel enable.
REQ-015 snooze  in  1  one-cycle snooze request.
REQ-016 dismiss  in  1  one-cycle dismiss request.
REQ-017 ring  out  1  buzzer drive, high while in RINGING.
REQ-018 ring_idx  out  IDXW  channel currently ringing or snoozed.
REQ-019 pending  out  NUM_ALARMS  per-channel queued-trigger flags.

Function
REQ-020 Channel N triggers on a clk where tick_1hz=1, enable=1, wr_mask[weekday_in]=1, weekday_in!=7, time_in[23:8]==alarm time, time_in[7:0]==8'h00.
REQ-021 States: IDLE, RINGING, SNOOZED; reset state IDLE.
REQ-022 IDLE: any trigger or pending bit -> RINGING on the next clk, lowest index wins; ring asserts one clk after the triggering tick.
REQ-023 Triggers arriving outside IDLE, or losing priority, set their pending bit; a pending bit clears when its channel enters RINGING.
REQ-024 RINGING: ring counter increments on tick_1hz; reaching RING_SECS -> IDLE, snooze count cleared.
REQ-025 RINGING + dismiss -> IDLE next clk; snooze count cleared.
REQ-026 RINGING + snooze with count<MAX_SNOOZE -> SNOOZED; target = time_in[23:8] + SNOOZE_MIN minutes, BCD, minute carry into hour, 23:5x wraps to 00:0y; count increments.
REQ-027 Snooze with count==MAX_SNOOZE is ignored; ringing continues.
REQ-028 Simultaneous snooze and dismiss: dismiss wins.
REQ-029 SNOOZED: tick_1hz with time_in==target,00 -> RINGING, counter restarts at 0; dismiss -> IDLE; weekday mask not rechecked.
REQ-030 Writes with any BCD nibble >9, hours >23 or minutes >59 are discarded.
REQ-031 Accepted write takes effect next clk; writing the channel in RINGING or SNOOZED aborts it to IDLE and clears its pending bit.
REQ-032 wr_idx >= NUM_ALARMS is discarded.

Reset
REQ-033 On rst low: state IDLE, ring=0, ring_idx=0, pending=0, all channels disabled, times 00:00, masks 0, counters 0, snooze target 00:00.
REQ-034 Reset mid-ring deasserts ring immediately (asynchronous); no pending state survives.

Configuration
REQ-035 Macro ALARM_SNOOZE_EN: defined -> SNOOZED state, snooze counter and target adder present per REQ-026..029.
REQ-036 Undefined -> snooze input ignored, SNOOZED state not built, MAX_SNOOZE unused; all other behaviour identical.

Verification
REQ-037 Ch0 07:30 mask 7'h7F enabled; time 07:29:59 -> 07:30:00 tick -> ring=1 next clk, ring_idx=0, drops after 60 ticks.
REQ-038 Ch1 and ch2 both 06:00, weekday 3 -> ring_idx=1, pending=4'b0100; dismiss -> ch2 rings next clk.
REQ-039 Ch0 23:57 ringing, snooze at 23:57:10 -> SNOOZED, ring=0; at 00:02:00 tick -> ring=1.
REQ-040 Three snoozes accepted, fourth snooze ignored (ring stays 1); snooze+dismiss same clk -> IDLE.
REQ-041 Write ch0 time 16'h2460 -> discarded, old time retained; weekday_in=7 with matching time -> no trigger.
REQ-042 rst low during RINGING -> ring=0 same cycle, pending=0; ALARM_SNOOZE_EN undefined build: snooze pulse has no effect.
